// File: rtl/alu_pipe_pkg.sv
// Shared types and limits for the flow-controlled ALU pipeline.
package alu_pipe_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_sel_e;

  localparam int MIN_STAGES = 3;
  localparam int MAX_STAGES = 8;

endpackage

// File: rtl/alu.sv
// Combinational two-operand ALU; all arithmetic wraps modulo 2^DWIDTH.
module alu
  import alu_pipe_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [1:0]        sel,
  output logic [DWIDTH-1:0] y
);

  always_comb begin
    y = a + b;
    case (alu_sel_e'(sel))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/pipe_slice.sv
// One valid/ready register stage: loads whenever it is empty or its consumer takes the current entry.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic advance;

  assign advance = !out_valid || out_ready;

  // Flush only kills the valid bit; payload is left stale on purpose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/alu_pipeline_hs.sv
// Flow-controlled ALU pipeline: op1 <sel> op2, optional "minus op1" chain step, then delay stages.
// Valid/ready: a stage loads when it is empty or its consumer is ready; accept = valid_i && ready_o.
module alu_pipeline_hs
  import alu_pipe_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  input  logic [1:0]        sel_i,
  input  logic              chain_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              zero_o,
  output logic              neg_o
);

  localparam int W1 = 2*DWIDTH + 3;
  localparam int W2 = 2*DWIDTH + 1;
  localparam int WT = DWIDTH + 2;

  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("alu_pipeline_hs: STAGES must be within 3..8");
  end

  logic [STAGES:1]           v;
  logic [STAGES:1]           dn_ready;
  logic [W1-1:0]             s1_data;
  logic [W2-1:0]             s2_data;
  logic [STAGES:3][WT-1:0]   td;

  logic [DWIDTH-1:0] s1_op1, s1_op2, s2_r1, s2_op1;
  logic [1:0]        s1_sel;
  logic              s1_chain, s2_chain;
  logic [DWIDTH-1:0] r1, diff, r2;
  logic [WT-1:0]     s3_in;

  // A stage's consumer is ready when ready_i is high or any later stage is empty;
  // this is the unrolled form of the per-stage ready chain and never depends on valid_i.
  for (genvar k = 1; k <= STAGES; k++) begin : g_ready
    if (k == STAGES) begin : g_last
      assign dn_ready[k] = ready_i;
    end else begin : g_mid
      assign dn_ready[k] = ready_i || !(&v[STAGES:k+1]);
    end
  end

  assign ready_o = !flush_i && (ready_i || !(&v));

  pipe_slice #(.W(W1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush_i),
    .in_valid(valid_i), .in_data({op1_i, op2_i, sel_i, chain_i}),
    .out_ready(dn_ready[1]), .out_valid(v[1]), .out_data(s1_data)
  );

  assign {s1_op1, s1_op2, s1_sel, s1_chain} = s1_data;

  alu #(.DWIDTH(DWIDTH)) u_alu_op (.a(s1_op1), .b(s1_op2), .sel(s1_sel), .y(r1));

  pipe_slice #(.W(W2)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush_i),
    .in_valid(v[1]), .in_data({r1, s1_op1, s1_chain}),
    .out_ready(dn_ready[2]), .out_valid(v[2]), .out_data(s2_data)
  );

  assign {s2_r1, s2_op1, s2_chain} = s2_data;

  alu #(.DWIDTH(DWIDTH)) u_alu_chain (.a(s2_r1), .b(s2_op1), .sel(ALU_SUB), .y(diff));

  assign r2    = s2_chain ? diff : s2_r1;
  // Flags travel with the value; delay stages never alter it, so they match res_o.
  assign s3_in = {(r2 == '0), r2[DWIDTH-1], r2};

  for (genvar k = 3; k <= STAGES; k++) begin : g_tail
    if (k == 3) begin : g_first
      pipe_slice #(.W(WT)) u_s (
        .clk(clk), .rst(rst), .flush(flush_i),
        .in_valid(v[2]), .in_data(s3_in),
        .out_ready(dn_ready[3]), .out_valid(v[3]), .out_data(td[3])
      );
    end else begin : g_delay
      pipe_slice #(.W(WT)) u_s (
        .clk(clk), .rst(rst), .flush(flush_i),
        .in_valid(v[k-1]), .in_data(td[k-1]),
        .out_ready(dn_ready[k]), .out_valid(v[k]), .out_data(td[k])
      );
    end
  end

  assign valid_o                 = v[STAGES];
  assign {zero_o, neg_o, res_o}  = td[STAGES];

endmodule

// File: tb/tb_alu_pipeline_hs.sv
// Randomized scoreboard bench for alu_pipeline_hs at STAGES=3 (main) and STAGES=6 (deep).
module tb_alu_pipeline_hs;
  import alu_pipe_pkg::*;

  localparam int DW  = 32;
  localparam int ST  = 3;
  localparam int ST6 = 6;
  localparam int EW  = DW + 18;

  logic          clk, rst;
  logic          flush_i, valid_i, ready_o, chain_i, valid_o, ready_i, zero_o, neg_o;
  logic [DW-1:0] op1_i, op2_i, res_o;
  logic [1:0]    sel_i;

  logic          flush6, valid6_i, ready6_o, chain6_i, valid6_o, ready6_i, zero6_o, neg6_o;
  logic [DW-1:0] op16_i, op26_i, res6_o;
  logic [1:0]    sel6_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit lat_check = 0;
  bit prev_stall = 0;
  logic [DW+1:0] prev_out;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp6_q[$];

  alu_pipeline_hs #(.DWIDTH(DW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op1_i(op1_i), .op2_i(op2_i), .sel_i(sel_i), .chain_i(chain_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .zero_o(zero_o), .neg_o(neg_o)
  );

  alu_pipeline_hs #(.DWIDTH(DW), .STAGES(ST6)) dut6 (
    .clk(clk), .rst(rst), .flush_i(flush6), .valid_i(valid6_i), .ready_o(ready6_o),
    .op1_i(op16_i), .op2_i(op26_i), .sel_i(sel6_i), .chain_i(chain6_i),
    .valid_o(valid6_o), .ready_i(ready6_i), .res_o(res6_o), .zero_o(zero6_o), .neg_o(neg6_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Packs {accept cycle, zero, neg, result} straight from the arithmetic rules.
  function automatic logic [EW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [1:0] s, input logic c, input int acc);
    logic [DW-1:0] r;
    case (s)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    if (c) r = r - a;
    return {acc[15:0], (r == 0), r[DW-1], r};
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out, expected completion (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard / monitor (main DUT) ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [15:0]   lat;
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", valid_o, 1'b1);
        chk("stall_hold", {zero_o, neg_o, res_o}, prev_out);
      end
      chk("ready_o", ready_o, !flush_i && (ready_i || exp_q.size() < ST));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("res", res_o, e[DW-1:0]);
          chk("flags", {zero_o, neg_o}, e[DW+1:DW]);
          if (lat_check) begin
            lat = cyc[15:0] - e[EW-1:DW+2];
            chk("latency", lat, ST);
          end
        end
      end
      if (flush_i) exp_q.delete();
      else if (valid_i && ready_o) exp_q.push_back(model(op1_i, op2_i, sel_i, chain_i, cyc));
      prev_stall = valid_o && !ready_i && !flush_i;
      prev_out   = {zero_o, neg_o, res_o};
    end
  end

  // ---------------- scoreboard / monitor (deep DUT) ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [15:0]   lat;
    if (rst) begin
      exp6_q.delete();
    end else begin
      if (valid6_o) begin
        if (exp6_q.size() == 0) begin
          chk("unexpected_out6", 1'b1, 1'b0);
        end else begin
          e = exp6_q.pop_front();
          chk("res6", res6_o, e[DW-1:0]);
          chk("flags6", {zero6_o, neg6_o}, e[DW+1:DW]);
          lat = cyc[15:0] - e[EW-1:DW+2];
          chk("latency6", lat, ST6);
        end
      end
      if (valid6_i) begin
        chk("ready6_o", ready6_o, 1'b1);
        if (ready6_o) exp6_q.push_back(model(op16_i, op26_i, sel6_i, chain6_i, cyc));
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    int pi = 0;
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       begin ready_i = (pi % 4 == 0) || (pi % 4 == 3); pi++; end
        2:       ready_i = 1'($urandom_range(0, 1));
        default: ready_i = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] s, input logic c);
    bit done = 0;
    op1_i = a; op2_i = b; sel_i = s; chain_i = c; valid_i = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (ready_o && !rst) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    valid_i = 1'b0;
    if (!done) timeout("send_accept");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
    op1_i = '0; op2_i = '0; sel_i = 2'b00; chain_i = 1'b0;
    flush6 = 1'b0; ready6_i = 1'b1; valid6_i = 1'b0;
    op16_i = '0; op26_i = '0; sel6_i = 2'b00; chain6_i = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_res_o", res_o, 0);
    chk("rst_flags", {zero_o, neg_o}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready_o", ready_o, 1'b1);

    // Directed: chain add, wrap-to-zero, negative sub
    lat_check = 1;
    send(32'd10, 32'd7, ALU_ADD, 1'b1);
    drain();
    send(32'hFFFF_FFFF, 32'd1, ALU_ADD, 1'b0);
    send(32'd3, 32'd5, ALU_SUB, 1'b0);
    drain();

    // Random, downstream always ready: latency is exact
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 2));
      send(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain();
    lat_check = 0;

    // Back-to-back with 1,0,0,1 backpressure
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) send(DW'(i), DW'(2 * i), ALU_ADD, 1'b1);
    drain();

    // Random stress with random backpressure and occasional flushes
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_flush();
      idle($urandom_range(0, 2));
      send(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();

    // Flush of a full, stalled pipeline
    rdy_mode = 3;
    idle(1);
    send(32'd1, 32'd2, ALU_ADD, 1'b0);
    send(32'd3, 32'd4, ALU_ADD, 1'b0);
    send(32'd5, 32'd6, ALU_OR, 1'b0);
    idle(1);
    pulse_flush();
    @(negedge clk);
    chk("flush_valid_o", valid_o, 1'b0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send(32'd100, 32'd23, ALU_AND, 1'b0);
    drain();

    // Asynchronous reset with two transactions in flight
    rdy_mode = 3;
    idle(1);
    send(32'd5, 32'd6, ALU_ADD, 1'b0);
    send(32'd7, 32'd8, ALU_ADD, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid_o", valid_o, 1'b0);
    chk("arst_res_o", res_o, 0);
    chk("arst_flags", {zero_o, neg_o}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    #1;
    chk("arst_ready_o", ready_o, 1'b1);
    idle(1);
    send(32'd9, 32'd4, ALU_SUB, 1'b1);
    drain();

    // Deep pipeline: OR then a random back-to-back stream
    op16_i = 32'h0F; op26_i = 32'hF0; sel6_i = ALU_OR; chain6_i = 1'b0; valid6_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      op16_i = rnd_op(); op26_i = rnd_op();
      sel6_i = 2'($urandom_range(0, 3)); chain6_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    valid6_i = 1'b0;
    repeat (ST6 + 4) @(posedge clk);
    #1;
    if (exp6_q.size() != 0) timeout("drain6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipeline_hs.md
Name: alu_pipeline_hs

Overview:
- Parametrised, flow-controlled successor to the fixed three-stage add/subtract pipeline.
- Each accepted transaction carries two operands, an ALU select and a chain flag:
  - stage 2 computes op1 <sel> op2;
  - stage 3 optionally subtracts the original op1 from that result;
  - optional extra stages add pure delay.
- Full valid/ready backpressure at every stage, plus a synchronous flush.
- Sits between operand producers and consumers in the datapath test harnesses.

Parameters:
DWIDTH, 32, operand/result width in bits
STAGES, 3, total register stages from input to res_o; legal range 3..8; stages 4..STAGES are delay-only

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
flush_i  input  1  synchronous flush: invalidates all in-flight transactions
valid_i  input  1  upstream transaction valid
ready_o  output  1  block can accept this cycle
op1_i  input  DWIDTH  first operand
op2_i  input  DWIDTH  second operand
sel_i  input  2  ALU op: 00 add, 01 sub, 10 and, 11 or
chain_i  input  1  1: stage 3 computes r1 - op1; 0: stage 3 passes r1
valid_o  output  1  res_o/flags valid
ready_i  input  1  downstream can accept
res_o  output  DWIDTH  result
zero_o  output  1  res_o == 0
neg_o  output  1  res_o[DWIDTH-1]

Behaviour:
- Reset (asynchronous, active-high):
  - all stage valid bits, data, sel and chain registers clear to 0;
  - valid_o=0, res_o=0, zero_o=0, neg_o=0;
  - ready_o=1 as soon as rst deasserts.
- Accept when valid_i && ready_o. Output handshake occurs when valid_o && ready_i.
- Stage k (k=1..STAGES) holds valid_k plus its payload.
  - Stage k advances if !valid_k || ready into stage k+1.
  - Ready into stage STAGES+1 is ready_i.
  - ready_o = !valid_1 || stage 1 advances. This is a combinational chain; no combinational path from valid_i to ready_o.
- Stage 1 registers op1, op2, sel and chain.
- Stage 2 registers r1 = op1 <sel> op2 (mod 2^DWIDTH, wrap-around, no carry out) and carries op1 and chain.
- Stage 3 registers r2 = chain ? (r1 - op1) mod 2^DWIDTH : r1.
- Stages 4..STAGES copy r2 unchanged.
- zero_o and neg_o are registered alongside res_o in the last stage, computed from the value entering it.
- Latency: a result appears on valid_o exactly STAGES cycles after acceptance when ready_i is held high. Throughput is 1 per cycle.
- Stall: while valid_o && !ready_i, res_o, zero_o and neg_o hold stable.
  - Bubbles upstream still compress: a stage with valid=0 accepts.
  - Once all STAGES are valid, ready_o=0.
  - No transaction is ever dropped or duplicated.
- flush_i=1 at a clock edge:
  - all valid bits clear next cycle and no input is accepted that cycle; ready_o is forced 0 while flush_i=1;
  - data registers may hold stale values;
  - res_o is not required to change, only valid_o=0.
- Flush has priority over any simultaneous accept or output handshake. The downstream must treat a valid_o handshake in the flush cycle as completed.
- Reset mid-operation: all in-flight data is discarded immediately and asynchronously.
- STAGES out of range: elaboration-time error.

Decomposition:
- Package alu_pipe_pkg: alu_sel_e enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11), MIN_STAGES=3, MAX_STAGES=8.
- Reuse the existing alu module for both arithmetic stages: sel from payload, and a constant SUB for the chain stage.
- One natural sub-module: pipe_slice. It is a parametrised-width valid/ready register with async reset and a flush input, instantiated per stage via generate.

Test Plan:
- Chain add, no stall: DWIDTH=32, STAGES=3, ready_i=1; send op1=10, op2=7, sel=00, chain=1 -> after exactly 3 cycles valid_o=1, res_o=7, zero_o=0, neg_o=0.
- Wrap and flags: op1=0xFFFFFFFF, op2=1, add, chain=0 -> res_o=0, zero_o=1. Then op1=3, op2=5, sub, chain=0 -> res_o=0xFFFFFFFE, neg_o=1.
- Back-to-back with backpressure: stream 10 transactions (op1=i, op2=2i, add, chain=1) with ready_i toggling 1,0,0,1,… -> outputs in order, res_o=2i, none lost or duplicated, res_o stable while stalled, ready_o=0 only after 3 stalled entries.
- Deep pipeline: STAGES=6, op1=0x0F, op2=0xF0, sel=11 (OR), chain=0 -> res_o=0xFF exactly 6 cycles after accept.
- Flush: fill 3 stages with ready_i=0, pulse flush_i one cycle -> valid_o=0 next cycle. A new transaction accepted after the flush emerges with the correct result; no flushed result ever appears.
- Async reset mid-stream: assert rst between clock edges with 2 transactions in flight -> valid_o, res_o and flags are 0 immediately without a clock edge. After release, ready_o=1 and a fresh transaction completes normally.
